clk_gen_downsampler: RTL and testbench

- Programmable, glitch-free clock divider clocked directly by the ring-oscillator loop output, i.e. the consumer end of the clock-generator chain.
- Produces a divided clock `clk_o` with a 50% duty cycle, plus a one-cycle rising-edge strobe.
- The divide ratio is reprogrammed at runtime through a valid/ready handshake. A new ratio takes effect only at a full output-period boundary.

---
 rtl/clk_gen_downsampler.sv | 134 +++++++++++++
 tb/tb_clk_gen_downsampler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/clk_gen_downsampler.sv
// Programmable glitch-free clock divider with a 50% duty cycle.
// clk_i is the ring-oscillator output, and all logic runs on its rising edge.
// Output period is 2*(ratio+1) input cycles. tick_o pulses in the cycle clk_o rises.
// A new ratio arrives on a valid/ready handshake. It is staged first, then applied at a
// falling toggle, so every output phase is a whole number of ratio+1 cycles.
// Optional feature: define CLK_GEN_DS_LOCK_EN to add lock_o. lock_o asserts after
// lock_periods_p complete output periods with no ratio change.
module clk_gen_downsampler #(
  parameter int unsigned width_p        = 8,
  parameter int unsigned init_ratio_p   = 0,
  parameter int unsigned lock_periods_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               val_i,
  input  logic [width_p-1:0] ratio_i,
  output logic               ready_o,
  output logic               clk_o,
  output logic               tick_o
`ifdef CLK_GEN_DS_LOCK_EN
  ,
  output logic               lock_o
`endif
);

  logic [width_p-1:0] cnt_q, cnt_d;
  logic [width_p-1:0] ratio_q, ratio_d;
  logic [width_p-1:0] pend_ratio_q, pend_ratio_d;
  logic               pending_q, pending_d;
  logic               clk_q, clk_d;
  logic               tick_q, tick_d;
  logic               ready_q, ready_d;

  logic toggle;
  logic fall;
  logic apply;
  logic accept;

  // Event decode: a toggle ends the current phase. The staged ratio is applied only
  // on a falling toggle, so the low phase that follows already uses it.
  always_comb begin
    toggle = (cnt_q == ratio_q);
    fall   = toggle & clk_q;
    apply  = fall & pending_q;
    accept = val_i & ready_q;
  end

  // Next-state logic for the counter, the output clock and the staging register.
  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    clk_d        = clk_q;
    tick_d       = 1'b0;
    ratio_d      = ratio_q;
    pend_ratio_d = pend_ratio_q;
    pending_d    = pending_q;

    if (toggle) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = ~clk_q;
    end

    if (apply) begin
      ratio_d   = pend_ratio_q;
      pending_d = 1'b0;
    end

    // Apply and accept never collide: ready_q is low whenever pending_q is high.
    if (accept) begin
      pend_ratio_d = ratio_i;
      pending_d    = 1'b1;
    end

    ready_d = ~pending_d;
  end

  // State registers with synchronous reset. Reset discards any staged ratio.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q        <= '0;
      clk_q        <= 1'b0;
      tick_q       <= 1'b0;
      ratio_q      <= width_p'(init_ratio_p);
      pend_ratio_q <= '0;
      pending_q    <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      clk_q        <= clk_d;
      tick_q       <= tick_d;
      ratio_q      <= ratio_d;
      pend_ratio_q <= pend_ratio_d;
      pending_q    <= pending_d;
      ready_q      <= ready_d;
    end
  end

  assign clk_o   = clk_q;
  assign tick_o  = tick_q;
  assign ready_o = ready_q;

`ifdef CLK_GEN_DS_LOCK_EN
  localparam int unsigned LockW = (lock_periods_p < 1) ? 1 : $clog2(lock_periods_p + 1);
  localparam logic [LockW-1:0] LockMax = LockW'(lock_periods_p);

  logic [LockW-1:0] per_cnt_q, per_cnt_d;
  logic             lock_q, lock_d;

  // Count unchanged full periods, saturating at the limit. Any apply restarts the count.
  always_comb begin
    per_cnt_d = per_cnt_q;
    if (apply) begin
      per_cnt_d = '0;
    end else if (fall && (per_cnt_q != LockMax)) begin
      per_cnt_d = per_cnt_q + 1'b1;
    end
    lock_d = (per_cnt_d == LockMax);
  end

  // Lock state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      per_cnt_q <= '0;
      lock_q    <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      lock_q    <= lock_d;
    end
  end

  assign lock_o = lock_q;
`endif

endmodule

// File: tb/tb_clk_gen_downsampler.sv
// Randomized scoreboard bench for clk_gen_downsampler.
// The reference model tracks the cycles left in each output phase. It does not mirror
// the RTL's up-counter.
module tb_clk_gen_downsampler;

  localparam int unsigned W     = 8;
  localparam int unsigned Init  = 0;
  localparam int unsigned LockP = 4;
  localparam int          NCyc  = 9000;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         val_i;
  logic [W-1:0] ratio_i;
  logic         ready_o;
  logic         clk_o;
  logic         tick_o;
  logic         lock_w;

  always #5 clk_i = ~clk_i;

  clk_gen_downsampler #(
    .width_p       (W),
    .init_ratio_p  (Init),
    .lock_periods_p(LockP)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .val_i  (val_i),
    .ratio_i(ratio_i),
    .ready_o(ready_o),
    .clk_o  (clk_o),
    .tick_o (tick_o)
`ifdef CLK_GEN_DS_LOCK_EN
    ,
    .lock_o (lock_w)
`endif
  );

`ifndef CLK_GEN_DS_LOCK_EN
  assign lock_w = 1'b0;
`endif

  typedef struct packed {
    logic clk;
    logic tick;
    logic ready;
    logic lock;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit m_lvl;
  int m_left;
  int m_ratio;
  bit m_pend;
  int m_pend_ratio;
  int m_per;
  bit m_tick;
  bit m_ready = 1'b1;

  // Advance the model by one rising edge. Report whether a request was accepted.
  task automatic model_step(input bit rst, input bit val, input int rin, output bit acc);
    bit applied;
    acc = 1'b0;
    applied = 1'b0;
    if (rst) begin
      m_lvl   = 1'b0;
      m_ratio = Init;
      m_left  = Init + 1;
      m_pend  = 1'b0;
      m_tick  = 1'b0;
      m_per   = 0;
      m_ready = 1'b1;
      return;
    end
    acc = val && m_ready;
    m_tick = 1'b0;
    m_left = m_left - 1;
    if (m_left == 0) begin
      if (m_lvl) begin
        if (m_pend) begin
          m_ratio = m_pend_ratio;
          m_pend  = 1'b0;
          applied = 1'b1;
          m_per   = 0;
        end else if (m_per < LockP) begin
          m_per = m_per + 1;
        end
      end
      m_lvl  = ~m_lvl;
      m_tick = m_lvl;
      m_left = m_ratio + 1;
    end
    if (acc) begin
      m_pend       = 1'b1;
      m_pend_ratio = rin;
    end
    m_ready = !m_pend;
    if (applied) m_ready = 1'b1;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Monitor: every edge yields an output sample, compared at the following negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("clk_o", clk_o, e.clk);
        check("tick_o", tick_o, e.tick);
        check("ready_o", ready_o, e.ready);
`ifdef CLK_GEN_DS_LOCK_EN
        check("lock_o", lock_w, e.lock);
`endif
      end
    end
  end

  // Stimulus: reset, idle at the reset ratio, one directed request, then random traffic
  initial begin
    bit   acc;
    bit   req;
    exp_t e;
    reset_i = 1'b1;
    val_i   = 1'b0;
    ratio_i = '0;
    req     = 1'b0;
    for (int c = 0; c < NCyc; c++) begin
      @(posedge clk_i);
      model_step(reset_i, val_i, int'(ratio_i), acc);
      e.clk   = m_lvl;
      e.tick  = m_tick;
      e.ready = m_ready;
      e.lock  = (m_per == LockP);
      exp_q.push_back(e);
      if (acc) req = 1'b0;
      #1;
      reset_i = (c < 1) || ($urandom_range(0, 799) == 0);
      if (reset_i) req = 1'b0;
      if (c == 22) begin
        req     = 1'b1;
        ratio_i = W'(3);
      end else if (c > 60 && !req && $urandom_range(0, 24) == 0) begin
        req     = 1'b1;
        ratio_i = ($urandom_range(0, 59) == 0) ? W'(255) : W'($urandom_range(0, 9));
      end else if (req && $urandom_range(0, 7) == 0) begin
        // The sender changes its held ratio before the request is accepted.
        ratio_i = W'($urandom_range(0, 9));
      end
      val_i = req;
    end
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
